// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle issue controller between the core control FSM and the ALU.
// Latches one operation per start pulse and drives stable operands to the ALU.
// It holds alu_en low for one load cycle so the shifter can preload, then raises it.
// Single-pass ops are sampled after FIX_LAT EXEC cycles. Shifts wait for alu_is_rd.
// Completion returns result/cmp/carry with a one-cycle done pulse.
// Illegal opcodes and timeouts complete with err=1, so the core never hangs.
//
// Ports:
//   clk, reset         clock, synchronous active-low reset
//   start, decinst     issue request (sampled in IDLE) and decoded instruction
//   rs1_in/rs2_in/imm_in  operands, latched on accept
//   busy, done         in-flight flag and one-cycle completion pulse
//   result, cmp_out, carry_out, rd_we, err   completion payload, held until next done
//   alu_en, alu_decinst, alu_rs1/rs2/imm     ALU drive
//   alu_rd, alu_cmp, alu_carry, alu_is_rd, alu_is_inst   ALU status
//   perf_ops, perf_stall  (only with ALU_SEQ_PERF_EN) completed-op and EXEC-cycle counters
//
// Optional feature macro: ALU_SEQ_PERF_EN
module alu_sequencer #(
    parameter int unsigned FIX_LAT = 2,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] decinst,
    input  logic [31:0] rs1_in,
    input  logic [31:0] rs2_in,
    input  logic [31:0] imm_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        cmp_out,
    output logic        carry_out,
    output logic        rd_we,
    output logic        err,
    output logic        alu_en,
    output logic [11:0] alu_decinst,
    output logic [31:0] alu_rs1,
    output logic [31:0] alu_rs2,
    output logic [31:0] alu_imm,
    input  logic [31:0] alu_rd,
    input  logic        alu_cmp,
    input  logic        alu_carry,
    input  logic        alu_is_rd,
    input  logic        alu_is_inst
`ifdef ALU_SEQ_PERF_EN
    ,
    output logic [31:0] perf_ops,
    output logic [31:0] perf_stall
`endif
);

    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EXEC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             is_shift, is_branch;
    logic             finish, cap_rd, cap_flags, set_rd_we, set_err;

    // Op class decode from the latched instruction
    assign is_branch = (alu_decinst[6:0] == 7'b1100011);
    assign is_shift  = ((alu_decinst[6:0] == 7'b0010011) || (alu_decinst[6:0] == 7'b0110011))
                     && ((alu_decinst[9:7] == 3'b001) || (alu_decinst[9:7] == 3'b101));

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state and completion strobes
    always_comb begin
        state_nxt = state;
        finish    = 1'b0;
        cap_rd    = 1'b0;
        cap_flags = 1'b0;
        set_rd_we = 1'b0;
        set_err   = 1'b0;
        unique case (state)
            S_IDLE: if (start) state_nxt = S_LOAD;
            S_LOAD: state_nxt = S_EXEC;
            S_EXEC: begin
                if ((cnt == '0) && !alu_is_inst) begin
                    finish  = 1'b1;
                    set_err = 1'b1;
                end else if (!is_shift && (cnt == CNT_W'(FIX_LAT - 1))) begin
                    // Branches only report the compare; rd is left untouched
                    finish    = 1'b1;
                    cap_flags = 1'b1;
                    cap_rd    = !is_branch;
                    set_rd_we = !is_branch;
                end else if (is_shift && alu_is_rd) begin
                    finish    = 1'b1;
                    cap_rd    = 1'b1;
                    set_rd_we = 1'b1;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    finish  = 1'b1;
                    set_err = 1'b1;
                end
                if (finish) state_nxt = S_DONE;
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Registered outputs, operand latches and the EXEC counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            alu_en      <= 1'b0;
            rd_we       <= 1'b0;
            err         <= 1'b0;
            result      <= '0;
            cmp_out     <= 1'b0;
            carry_out   <= 1'b0;
            alu_decinst <= '0;
            alu_rs1     <= '0;
            alu_rs2     <= '0;
            alu_imm     <= '0;
            cnt         <= '0;
        end else begin
            busy   <= (state_nxt != S_IDLE);
            done   <= (state_nxt == S_DONE);
            alu_en <= (state_nxt == S_EXEC) || (state_nxt == S_DONE);
            if ((state == S_IDLE) && start) begin
                alu_decinst <= decinst;
                alu_rs1     <= rs1_in;
                alu_rs2     <= rs2_in;
                alu_imm     <= imm_in;
            end
            // Saturating EXEC cycle count
            if (state == S_LOAD)
                cnt <= '0;
            else if ((state == S_EXEC) && (cnt != '1))
                cnt <= cnt + CNT_W'(1);
            if (finish) begin
                rd_we <= set_rd_we;
                err   <= set_err;
            end
            if (cap_rd) result <= alu_rd;
            if (cap_flags) begin
                cmp_out   <= alu_cmp;
                carry_out <= alu_carry;
            end
        end
    end

`ifdef ALU_SEQ_PERF_EN
    // Completed-op and EXEC-cycle counters, free-running modulo 2^32
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else begin
            if (finish)           perf_ops   <= perf_ops + 32'd1;
            if (state == S_EXEC)  perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer with a behavioural ALU and an expectation queue.
module tb_alu_sequencer;

    localparam int unsigned FIX_LAT = 2;
    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [11:0] decinst;
    logic [31:0] rs1_in, rs2_in, imm_in;
    logic        busy, done, cmp_out, carry_out, rd_we, err, alu_en;
    logic [31:0] result, alu_rs1, alu_rs2, alu_imm, alu_rd;
    logic [11:0] alu_decinst;
    logic        alu_cmp, alu_carry, alu_is_rd, alu_is_inst;
`ifdef ALU_SEQ_PERF_EN
    logic [31:0] perf_ops, perf_stall;
`endif

    int vectors = 0;
    int fails   = 0;

    typedef struct {
        logic [31:0] res;
        logic        cmp;
        logic        carry;
        logic        rd_we;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_sequencer #(.FIX_LAT(FIX_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start), .decinst(decinst),
        .rs1_in(rs1_in), .rs2_in(rs2_in), .imm_in(imm_in),
        .busy(busy), .done(done), .result(result), .cmp_out(cmp_out),
        .carry_out(carry_out), .rd_we(rd_we), .err(err), .alu_en(alu_en),
        .alu_decinst(alu_decinst), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
        .alu_imm(alu_imm), .alu_rd(alu_rd), .alu_cmp(alu_cmp),
        .alu_carry(alu_carry), .alu_is_rd(alu_is_rd), .alu_is_inst(alu_is_inst)
`ifdef ALU_SEQ_PERF_EN
        , .perf_ops(perf_ops), .perf_stall(perf_stall)
`endif
    );

    // Behavioural ALU: outputs are garbage until the op's latency has elapsed
    int          en_cnt;
    logic        force_no_rd = 1'b0;
    logic [6:0]  m_op;
    logic [2:0]  m_f3;
    logic [31:0] m_b;
    logic [4:0]  m_sh;
    logic [32:0] m_sum;

    always_ff @(posedge clk) en_cnt <= alu_en ? en_cnt + 1 : 0;

    always_comb begin
        m_op  = alu_decinst[6:0];
        m_f3  = alu_decinst[9:7];
        m_b   = (m_op == 7'b0110011) ? alu_rs2 : alu_imm;
        m_sh  = m_b[4:0];
        m_sum = {1'b0, alu_rs1} + {1'b0, m_b};
        alu_is_inst = (m_op == 7'b0010011) || (m_op == 7'b0110011) || (m_op == 7'b1100011);
        alu_rd    = 32'hDEAD_BEEF;
        alu_cmp   = 1'b1;
        alu_carry = 1'b1;
        alu_is_rd = 1'b0;
        if (m_op == 7'b1100011) begin
            if (en_cnt >= int'(FIX_LAT) - 1) begin
                alu_rd    = m_sum[31:0];
                alu_cmp   = (m_f3 == 3'b000) ? (alu_rs1 == alu_rs2) : (alu_rs1 != alu_rs2);
                alu_carry = m_sum[32];
            end
        end else if (alu_is_inst && ((m_f3 == 3'b001) || (m_f3 == 3'b101))) begin
            if (!force_no_rd && (en_cnt >= (int'(m_sh) >> 2) + 1)) begin
                alu_is_rd = 1'b1;
                alu_rd    = (m_f3 == 3'b001) ? (alu_rs1 << m_sh) : (alu_rs1 >> m_sh);
            end
        end else if (alu_is_inst) begin
            if (en_cnt >= int'(FIX_LAT) - 1) begin
                alu_rd    = m_sum[31:0];
                alu_cmp   = 1'b0;
                alu_carry = m_sum[32];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op from IDLE, then follow it to done and score the completion
    task automatic issue(input logic [11:0] dec, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] e_res, input logic e_cmp,
                         input logic e_carry, input logic e_rdwe, input logic e_err,
                         input int e_lat, input int hold_start);
        exp_t e;
        bit   seen = 1'b0;
        @(negedge clk);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        decinst = dec; rs1_in = a; rs2_in = b; imm_in = c; start = 1'b1;
        sb.push_back('{res: e_res, cmp: e_cmp, carry: e_carry, rd_we: e_rdwe, err: e_err, lat: e_lat});
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            start = (k <= hold_start);
            if (k == 1) begin
                rs1_in  = $urandom();
                rs2_in  = $urandom();
                imm_in  = $urandom();
                decinst = 12'($urandom());
            end
            chk("busy", 32'(busy), 32'd1);
            if (k == 1) chk("load_en", 32'(alu_en), 32'd0);
            if (k == 2) begin
                chk("exec_en", 32'(alu_en), 32'd1);
                chk("latched_rs1", alu_rs1, a);
            end
            if (done) begin
                seen = 1'b1;
                e = sb.pop_front();
                chk("latency", 32'(k), 32'(e.lat));
                chk("result", result, e.res);
                chk("cmp_out", 32'(cmp_out), 32'(e.cmp));
                chk("carry_out", 32'(carry_out), 32'(e.carry));
                chk("rd_we", 32'(rd_we), 32'(e.rd_we));
                chk("err", 32'(err), 32'(e.err));
            end
        end
        start = 1'b0;
        if (!seen) begin
            vectors++;
            fails++;
            $error("FAIL done_timeout: observed no done, expected done at cycle %0d", e_lat);
            void'(sb.pop_front());
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_we", 32'(rd_we), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_alu_en", 32'(alu_en), 32'd0);
        chk("rst_cmp", 32'(cmp_out), 32'd0);
        chk("rst_carry", 32'(carry_out), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_decinst", 32'(alu_decinst), 32'd0);
        chk("rst_rs1", alu_rs1, 32'd0);
    endtask

    localparam logic [11:0] ADD  = 12'b000000110011;
    localparam logic [11:0] ADDI = 12'b000000010011;
    localparam logic [11:0] BEQ  = 12'b000001100011;
    localparam logic [11:0] BNE  = 12'b000011100011;
    localparam logic [11:0] SLLI = 12'b000010010011;
    localparam logic [11:0] SRL  = 12'b001010110011;

    initial begin
        reset = 1'b0; start = 1'b0; decinst = '0;
        rs1_in = '0; rs2_in = '0; imm_in = '0;
        repeat (2) @(negedge clk);
        chk_reset_state();
        reset = 1'b1;

        issue(ADD,  32'd5,      32'd7,      32'd0,  32'd12,         1'b0, 1'b0, 1'b1, 1'b0, 4,  0);
        issue(BEQ,  32'h1234,   32'h1234,   32'd0,  32'd12,         1'b1, 1'b0, 1'b0, 1'b0, 4,  0);
        issue(BNE,  32'h1234,   32'h1234,   32'd0,  32'd12,         1'b0, 1'b0, 1'b0, 1'b0, 4,  0);
        issue(SLLI, 32'd1,      32'd0,      32'd31, 32'h8000_0000,  1'b0, 1'b0, 1'b1, 1'b0, 11, 0);
        issue(12'd0, 32'd3,     32'd4,      32'd5,  32'h8000_0000,  1'b0, 1'b0, 1'b0, 1'b1, 3,  2);
        issue(ADD,  32'hFFFF_FFFF, 32'd1,   32'd0,  32'd0,          1'b0, 1'b1, 1'b1, 1'b0, 4,  0);
        issue(ADDI, 32'd10,     32'd0,      32'hFFFF_FFFF, 32'd9,   1'b0, 1'b1, 1'b1, 1'b0, 4,  0);
        force_no_rd = 1'b1;
        issue(SRL,  32'h80,     32'd3,      32'd0,  32'd9,          1'b0, 1'b1, 1'b0, 1'b1, 2 + int'(TIMEOUT), 0);

        // Retry the stuck shift and reset in the middle of EXEC
        @(negedge clk);
        decinst = SRL; rs1_in = 32'h80; rs2_in = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_exec_en", 32'(alu_en), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        chk_reset_state();
        reset = 1'b1;
        force_no_rd = 1'b0;

        issue(ADD,  32'd3,      32'd4,      32'd0,  32'd7,          1'b0, 1'b0, 1'b1, 1'b0, 4,  0);
        issue(SRL,  32'h80,     32'd3,      32'd0,  32'h10,         1'b0, 1'b0, 1'b1, 1'b0, 4,  0);

`ifdef ALU_SEQ_PERF_EN
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("perf_ops_rst", perf_ops, 32'd0);
        issue(ADD, 32'd1, 32'd2, 32'd0, 32'd3, 1'b0, 1'b0, 1'b1, 1'b0, 4, 0);
        issue(ADD, 32'd3, 32'd3, 32'd0, 32'd6, 1'b0, 1'b0, 1'b1, 1'b0, 4, 0);
        issue(ADD, 32'd6, 32'd3, 32'd0, 32'd9, 1'b0, 1'b0, 1'b1, 1'b0, 4, 0);
        chk("perf_ops", perf_ops, 32'd3);
        chk("perf_stall", perf_stall, 32'd6);
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle issue controller between the core control FSM and the ALU.
- Latches one operation per start pulse and presents stable operands to the ALU.
- Drives the ALU enable, including the en-low load cycle the shifter needs.
- Waits a fixed latency for single-pass ops, or for is_rd on shifts; then returns result/cmp/carry with a one-cycle done pulse.
- Adds illegal-opcode and timeout detection so the core never hangs on the ALU.

Parameters:
- FIX_LAT, 2, EXEC cycles before sampling non-shift results (1 + REG_ALU + REG_OUT of the ALU instance; legal 1..3).
- TIMEOUT, 16, maximum EXEC cycles for any op before an error completion (must exceed 10, the worst shift of 31).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- start  in  1  issue request, sampled only in IDLE
- decinst  in  12  decoded instruction code (ALU encoding)
- rs1_in  in  32  operand 1
- rs2_in  in  32  operand 2
- imm_in  in  32  immediate
- busy  out  1  high from the cycle after accepted start through DONE
- done  out  1  one-cycle completion pulse
- result  out  32  captured rd value, held until next done
- cmp_out  out  1  captured branch compare
- carry_out  out  1  captured carry
- rd_we  out  1  valid with done: write rd
- err  out  1  valid with done: illegal opcode or timeout
- alu_en  out  1  ALU enable
- alu_decinst  out  12  latched decinst
- alu_rs1, alu_rs2, alu_imm  out  32 each  latched operands
- alu_rd  in  32  ALU result
- alu_cmp, alu_carry, alu_is_rd, alu_is_inst  in  1 each  ALU status

Behaviour:
- Reset (reset==0 at posedge), from any state including mid-op: state=IDLE.
  - busy, done, rd_we, err, alu_en, cmp_out, carry_out = 0.
  - result = 0, latched operands = 0, counters = 0.
- Classes:
  - SHIFT: decinst[6:0] in {0010011, 0110011} and decinst[9:7] in {001, 101}.
  - BRANCH: decinst[6:0] == 1100011.
  - ALU: all other opcodes.
- IDLE: alu_en=0. When start=1, latch decinst/rs1/rs2/imm and go to LOAD.
- LOAD: exactly one cycle with alu_en=0 and latched operands driven; the ALU shifter preloads. Go to EXEC and clear cnt.
- EXEC: alu_en=1; cnt increments every cycle.
  - First EXEC cycle with alu_is_inst=0: go to DONE with err=1, rd_we=0.
  - ALU/BRANCH: when cnt == FIX_LAT-1, capture alu_rd, alu_cmp, alu_carry.
    - ALU: rd_we=1.
    - BRANCH: rd_we=0; result keeps its previous value.
    - Go to DONE.
  - SHIFT: when alu_is_rd=1, capture alu_rd, set rd_we=1, go to DONE.
  - cnt == TIMEOUT-1 with no completion: DONE with err=1, rd_we=0; captures not updated.
- DONE: done=1 for one cycle, alu_en still 1. Next state is IDLE, where alu_en=0.
- Latency: an accepted start at cycle 0 gives done at cycle 2+FIX_LAT for ALU/BRANCH ops; minimum turnaround between starts is 3+FIX_LAT.
- start while busy or in DONE: ignored, never queued.
- rd_we, err, cmp_out, carry_out: registered, change only on entry to DONE, hold until next DONE.
- Latched operands are stable from LOAD through DONE; input changes after accept have no effect.
- cnt is 5 bits and saturates, never wraps.

Optional Feature:
- Macro ALU_SEQ_PERF_EN.
- Defined: adds outputs perf_ops (32, increments at each DONE) and perf_stall (32, increments every EXEC cycle). Both cleared by reset and wrap modulo 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- add (decinst=000000110011), rs1=5, rs2=7, FIX_LAT=2, start at cycle 0 -> done at cycle 4, result=12, rd_we=1, err=0, carry_out=0.
- beq (000001100011), rs1=rs2=0x1234 -> done, cmp_out=1, rd_we=0, result unchanged from the prior op; then bne (000011100011) with the same operands -> cmp_out=0.
- slli (000010010011), rs1=1, imm=31 -> alu_en low for exactly 1 cycle after accept, then high; done after alu_is_rd, result=0x80000000, done within 12 cycles of start.
- decinst=0 -> done 3 cycles after start with err=1, rd_we=0; start pulses at cycles 1-2 ignored, busy stays 1.
- Forced alu_is_rd=0 on srl, TIMEOUT=16 -> done 16 EXEC cycles later with err=1; reset asserted mid-EXEC on a retry -> next cycle IDLE, all outputs 0.
- With ALU_SEQ_PERF_EN defined: 3 back-to-back adds -> perf_ops=3, perf_stall=6.
